// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and framing constants shared by the UART transmitter and receiver
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int DBITS = 8;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: upstream FIFO read port and serial line of the UART transmitter
interface uart_tx_if;
  import uart_pkg::*;
  logic fifo_empty;
  logic [DBITS-1:0] fifo_r_data;
  logic fifo_rd;
  logic tx;
  logic tx_busy;
  logic tx_done_tick;
  modport master (input fifo_empty, fifo_r_data, output fifo_rd, tx, tx_busy, tx_done_tick);
  modport slave (output fifo_empty, fifo_r_data, input fifo_rd, tx, tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: DVSR-modulo counter with synchronous clear producing a one-cycle oversample tick
module uart_baud_gen #(
  parameter int DVSR = 163
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(DVSR);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(DVSR - 1);
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter, 16x oversampled bit timing, optional parity, 1 or 2 stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int DVSR = 163,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst,
  uart_tx_if.master io
);
  localparam logic [4:0] BIT_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(OVERSAMPLE * STOP_BITS - 1);
  state_t state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [DBITS:0] sh_q, sh_d;
  logic tx_q, tx_d, done_q, done_d, tick, bit_end, par;
  uart_baud_gen #(.DVSR(DVSR)) u_baud (.clk(clk), .rst(rst), .clr_i(io.fifo_rd), .tick_o(tick));
  assign io.fifo_rd = rst && state_q == S_IDLE && !io.fifo_empty;
  assign io.tx = tx_q;
  assign io.tx_busy = state_q != S_IDLE;
  assign io.tx_done_tick = done_q;
  assign par = (^io.fifo_r_data) ^ (PARITY == PAR_ODD);
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    n_d = n_q;
    sh_d = sh_q;
    done_d = 1'b0;
    bit_end = tick && s_q == (state_q == S_STOP ? STOP_LAST : BIT_LAST);
    if (state_q != S_IDLE && tick) s_d = bit_end ? '0 : s_q + 1'b1;
    case (state_q)
      S_IDLE: if (io.fifo_rd) begin
        state_d = S_START;
        s_d = '0;
        n_d = '0;
        sh_d = {par, io.fifo_r_data};
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: if (bit_end) begin
        sh_d = sh_q >> 1;
        n_d = n_q + 1'b1;
        if (n_q == 3'(DBITS - 1)) state_d = PARITY == PAR_NONE ? S_STOP : S_PARITY;
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: if (bit_end) begin
        state_d = S_IDLE;
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    tx_d = state_d == S_START ? 1'b0 : (state_d == S_DATA || state_d == S_PARITY) ? sh_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s_q <= '0;
      n_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      n_q <= n_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed scenarios on four transmitter configurations (DVSR = 2, one bit = 32 clk)
module tb_uart_tx;
  localparam int N = 1100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] empty_r = 4'hF;
  logic [7:0] data_r [4];
  logic [3:0] tx_w, rd_w, busy_w, done_w;
  logic tr_tx [N];
  logic tr_rd [N];
  logic tr_busy [N];
  logic tr_done [N];
  logic [7:0] fq [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_if u0 ();
  uart_tx_if u1 ();
  uart_tx_if u2 ();
  uart_tx_if u3 ();
  assign u0.fifo_empty = empty_r[0];
  assign u1.fifo_empty = empty_r[1];
  assign u2.fifo_empty = empty_r[2];
  assign u3.fifo_empty = empty_r[3];
  assign u0.fifo_r_data = data_r[0];
  assign u1.fifo_r_data = data_r[1];
  assign u2.fifo_r_data = data_r[2];
  assign u3.fifo_r_data = data_r[3];
  assign tx_w = {u3.tx, u2.tx, u1.tx, u0.tx};
  assign rd_w = {u3.fifo_rd, u2.fifo_rd, u1.fifo_rd, u0.fifo_rd};
  assign busy_w = {u3.tx_busy, u2.tx_busy, u1.tx_busy, u0.tx_busy};
  assign done_w = {u3.tx_done_tick, u2.tx_done_tick, u1.tx_done_tick, u0.tx_done_tick};

  uart_tx #(.DVSR(2), .PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .rst(rst), .io(u0));
  uart_tx #(.DVSR(2), .PARITY(1), .STOP_BITS(1)) dut1 (.clk(clk), .rst(rst), .io(u1));
  uart_tx #(.DVSR(2), .PARITY(2), .STOP_BITS(1)) dut2 (.clk(clk), .rst(rst), .io(u2));
  uart_tx #(.DVSR(2), .PARITY(0), .STOP_BITS(2)) dut3 (.clk(clk), .rst(rst), .io(u3));

  // Acts as the upstream FIFO for instance s and traces its outputs once per cycle;
  // rst is pulled low for two cycles starting at cycle rst_at (negative: never).
  task automatic record(input int s, input int n, input int rst_at);
    for (int i = 0; i < N; i++) begin
      tr_tx[i] = 1'b1;
      tr_rd[i] = 1'b0;
      tr_busy[i] = 1'b0;
      tr_done[i] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = !(rst_at >= 0 && i >= rst_at && i < rst_at + 2);
      empty_r[s] = fq.size() == 0;
      data_r[s] = fq.size() != 0 ? fq[0] : 8'hC3;
      #1;
      tr_tx[i] = tx_w[s];
      tr_rd[i] = rd_w[s];
      tr_busy[i] = busy_w[s];
      tr_done[i] = done_w[s];
      if (rd_w[s]) void'(fq.pop_front());
    end
  endtask

  function automatic logic txa(input int i);
    return (i >= 0 && i < N) ? tr_tx[i] : 1'bx;
  endfunction

  // kind 0: tx low, 1: fifo_rd, 2: tx_done_tick
  function automatic int find(input int kind, input int from);
    for (int i = (from < 0 ? 0 : from); i < N; i++)
      if (kind == 0 ? tr_tx[i] === 1'b0 : kind == 1 ? tr_rd[i] === 1'b1 : tr_done[i] === 1'b1) return i;
    return -1;
  endfunction

  // kind 0: tx low, 1: fifo_rd, 2: tx_done_tick, 3: tx_busy
  function automatic int count(input int kind);
    int c = 0;
    for (int i = 0; i < N; i++)
      if (kind == 0 ? tr_tx[i] === 1'b0 : kind == 1 ? tr_rd[i] === 1'b1 :
          kind == 2 ? tr_done[i] === 1'b1 : tr_busy[i] === 1'b1) c++;
    return c;
  endfunction

  // Reads a frame whose start bit begins at cycle f: start-bit length, mid-bit data and parity,
  // tx_done_tick offset from f, and the number of high cycles from stop start up to that tick.
  task automatic decode(input int f, input int npar, output logic [7:0] d, output logic p,
                        output int low, output int done_off, output int ones);
    low = 0;
    while (txa(f + low) === 1'b0 && low < 100) low++;
    for (int k = 0; k < 8; k++) d[k] = txa(f + 32 * k + 48);
    p = txa(f + 304);
    done_off = find(2, f) - f;
    ones = 0;
    for (int j = f + 32 * (9 + npar); j < f + done_off; j++) if (txa(j) === 1'b1) ones++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    empty_r[0] = 1'b0;
    data_r[0] = 8'h99;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (tx_w !== 4'hF) begin miscompares++; $display("FAIL reset_tx: got %b expected 1111", tx_w); end
    vectors++; if (rd_w[0] !== 1'b0) begin miscompares++; $display("FAIL reset_rd: got %b expected 0 while rst low", rd_w[0]); end
    vectors++; if (busy_w !== 4'h0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0000", busy_w); end
    vectors++; if (done_w !== 4'h0) begin miscompares++; $display("FAIL reset_done: got %b expected 0000", done_w); end
    empty_r[0] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    int p, f, low, done_off, ones;
    logic [7:0] d, w;
    logic par;
    w = 8'h55;
    fq.delete();
    fq.push_back(w);
    record(0, 400, -1);
    p = find(1, 0);
    f = find(0, 0);
    decode(f, 0, d, par, low, done_off, ones);
    vectors++; if (count(1) !== 1) begin miscompares++; $display("FAIL single_pops: got %0d expected 1", count(1)); end
    vectors++; if (f !== p + 1) begin miscompares++; $display("FAIL single_start: fall at %0d expected %0d", f, p + 1); end
    vectors++; if (low !== 32) begin miscompares++; $display("FAIL single_start_len: got %0d expected 32", low); end
    vectors++; if (d !== w) begin miscompares++; $display("FAIL single_data: got %h expected %h", d, w); end
    for (int k = 0; k < 8; k++) begin
      vectors++; if (txa(f + 32 * k + 32) !== w[k] || txa(f + 32 * k + 63) !== w[k]) begin
        miscompares++; $display("FAIL single_bit%0d_edges: got %b/%b expected %b", k, txa(f + 32 * k + 32), txa(f + 32 * k + 63), w[k]);
      end
    end
    vectors++; if (ones !== 32) begin miscompares++; $display("FAIL single_stop_len: got %0d expected 32", ones); end
    vectors++; if (done_off !== 320) begin miscompares++; $display("FAIL single_done_time: got %0d expected 320", done_off); end
    vectors++; if (count(2) !== 1) begin miscompares++; $display("FAIL single_done_count: got %0d expected 1", count(2)); end
    vectors++; if (tr_busy[f + 319] !== 1'b1 || tr_busy[f + 320] !== 1'b0) begin
      miscompares++; $display("FAIL single_busy_end: got %b%b expected 10", tr_busy[f + 319], tr_busy[f + 320]);
    end
  endtask

  task automatic test_back_to_back();
    int p0, p1, f0, f1, low, done_off, ones;
    logic [7:0] d;
    logic par;
    fq.delete();
    fq.push_back(8'h01);
    fq.push_back(8'h80);
    record(0, 800, -1);
    p0 = find(1, 0);
    p1 = find(1, p0 + 1);
    f0 = find(0, 0);
    f1 = find(0, f0 + 320);
    vectors++; if (count(1) !== 2) begin miscompares++; $display("FAIL b2b_pops: got %0d expected 2", count(1)); end
    // 321 cycles between pop cycles: both pop cycles included, the span covers 322 clk
    vectors++; if (p1 - p0 !== 321) begin miscompares++; $display("FAIL b2b_pop_gap: got %0d expected 321", p1 - p0); end
    vectors++; if (f1 - f0 !== 321) begin miscompares++; $display("FAIL b2b_frame_gap: got %0d expected 321", f1 - f0); end
    vectors++; if (txa(f1 - 1) !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_high: got %b expected 1", txa(f1 - 1)); end
    vectors++; if (find(2, f0) !== p1) begin miscompares++; $display("FAIL b2b_done_vs_pop: done %0d expected %0d", find(2, f0), p1); end
    decode(f0, 0, d, par, low, done_off, ones);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL b2b_data0: got %h expected 01", d); end
    decode(f1, 0, d, par, low, done_off, ones);
    vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL b2b_data1: got %h expected 80", d); end
    vectors++; if (done_off !== 320) begin miscompares++; $display("FAIL b2b_done1_time: got %0d expected 320", done_off); end
  endtask

  task automatic test_parity();
    int f, low, done_off, ones;
    logic [7:0] d;
    logic par;
    for (int s = 1; s <= 2; s++) begin
      fq.delete();
      fq.push_back(8'h07);
      record(s, 400, -1);
      f = find(0, 0);
      decode(f, 1, d, par, low, done_off, ones);
      vectors++; if (d !== 8'h07) begin miscompares++; $display("FAIL parity%0d_data: got %h expected 07", s, d); end
      vectors++; if (par !== (s == 1)) begin miscompares++; $display("FAIL parity%0d_bit: got %b expected %b", s, par, s == 1); end
      vectors++; if (done_off !== 352) begin miscompares++; $display("FAIL parity%0d_len: got %0d expected 352", s, done_off); end
      vectors++; if (ones !== 32) begin miscompares++; $display("FAIL parity%0d_stop: got %0d expected 32", s, ones); end
    end
  endtask

  task automatic test_stop_bits();
    int f, low, done_off, ones;
    logic [7:0] d;
    logic par;
    fq.delete();
    fq.push_back(8'hFF);
    record(3, 400, -1);
    f = find(0, 0);
    decode(f, 0, d, par, low, done_off, ones);
    vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL stop2_data: got %h expected ff", d); end
    vectors++; if (low !== 32) begin miscompares++; $display("FAIL stop2_start_len: got %0d expected 32", low); end
    vectors++; if (ones !== 64) begin miscompares++; $display("FAIL stop2_stop_len: got %0d expected 64", ones); end
    vectors++; if (done_off !== 352) begin miscompares++; $display("FAIL stop2_done_time: got %0d expected 352", done_off); end
  endtask

  task automatic test_empty();
    fq.delete();
    record(0, 1000, -1);
    vectors++; if (count(1) !== 0) begin miscompares++; $display("FAIL empty_rd: got %0d pops expected 0", count(1)); end
    vectors++; if (count(3) !== 0) begin miscompares++; $display("FAIL empty_busy: got %0d busy cycles expected 0", count(3)); end
    vectors++; if (count(2) !== 0) begin miscompares++; $display("FAIL empty_done: got %0d ticks expected 0", count(2)); end
    vectors++; if (count(0) !== 0) begin miscompares++; $display("FAIL empty_tx: got %0d low cycles expected 0", count(0)); end
  endtask

  task automatic test_reset_mid();
    int p, f, low, done_off, ones;
    logic [7:0] d;
    logic par;
    fq.delete();
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    record(0, 500, 140);
    vectors++; if (txa(140) !== 1'b0) begin miscompares++; $display("FAIL rstmid_bit3: got %b expected 0", txa(140)); end
    vectors++; if (txa(141) !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: got %b expected 1", txa(141)); end
    vectors++; if (tr_busy[141] !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", tr_busy[141]); end
    vectors++; if (tr_rd[141] !== 1'b0) begin miscompares++; $display("FAIL rstmid_rd_in_reset: got %b expected 0", tr_rd[141]); end
    vectors++; if (count(1) !== 2) begin miscompares++; $display("FAIL rstmid_pops: got %0d expected 2", count(1)); end
    p = find(1, 1);
    vectors++; if (p !== 142) begin miscompares++; $display("FAIL rstmid_repop: got %0d expected 142", p); end
    f = find(0, 142);
    decode(f, 0, d, par, low, done_off, ones);
    vectors++; if (f !== 143) begin miscompares++; $display("FAIL rstmid_fall: got %0d expected 143", f); end
    vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL rstmid_data: got %h expected 3c", d); end
    vectors++; if (done_off !== 320) begin miscompares++; $display("FAIL rstmid_done_time: got %0d expected 320", done_off); end
    vectors++; if (count(2) !== 1) begin miscompares++; $display("FAIL rstmid_done_count: got %0d expected 1", count(2)); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_stop_bits();
    test_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
